// File: rtl/serial_tx_framer_pkg.sv
// Shared types and helpers for the serial transmit path (framer and future receive-side checker).
package serial_tx_framer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        GAP    = 2'd3
    } tx_state_t;

    // Zero-extension does not change the XOR, so one function serves every word width.
    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/serial_tx_framer_if.sv
// Parallel word handshake plus serial-side outputs of the framer.
interface serial_tx_framer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             s_out;
    logic             s_valid;
    logic             frame_start;
    logic             busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, s_out, s_valid, frame_start, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, s_out, s_valid, frame_start, busy
    );
endinterface

// File: rtl/serial_tx_framer_bit_tick_gen.sv
// Bit-time divider: counts 0..CLK_DIV-1 while enabled and pulses bit_tick on the last count.
module serial_tx_framer_bit_tick_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic bit_tick
);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign bit_tick = en && (cnt == LAST);

endmodule

// File: rtl/serial_tx_framer.sv
// Parallel-to-serial framer: data bits, optional even parity, optional idle gap, then IDLE.
module serial_tx_framer
    import serial_tx_framer_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 0,
    parameter int CLK_DIV   = 1,
    parameter int PARITY_EN = 1,
    parameter int GAP_BITS  = 1
) (
    input  logic clk,
    input  logic rst,
    serial_tx_framer_if.slave bus
);
    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam int GAP_W = $clog2(GAP_BITS + 2);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    tx_state_t        state, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             par_q, par_d;
    logic             s_out_q, s_out_d;
    logic             s_valid_q, s_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             load;
    logic             bit_tick;

    serial_tx_framer_bit_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .en       (state != IDLE),
        .clear    (state == IDLE),
        .bit_tick (bit_tick)
    );

    assign load = (state == IDLE) && bus.in_valid;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state;
        word_d    = word_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        par_d     = par_q;

        unique case (state)
            IDLE: begin
                if (load) begin
                    state_d   = DATA;
                    word_d    = bus.in_data;
                    par_d     = even_parity(64'(bus.in_data));
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    word_d = (MSB_FIRST != 0) ? (word_q << 1) : (word_q >> 1);
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        if (PARITY_EN != 0)    state_d = PARITY;
                        else if (GAP_BITS > 0) state_d = GAP;
                        else                   state_d = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) state_d = (GAP_BITS > 0) ? GAP : IDLE;
            end
            GAP: begin
                if (bit_tick) begin
                    if (gap_cnt_q == LAST_GAP) begin
                        gap_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the values the next cycle will hold.
        s_valid_d     = (state_d == DATA) || (state_d == PARITY);
        frame_start_d = load;
        s_out_d       = 1'b0;
        if (state_d == DATA)
            s_out_d = (MSB_FIRST != 0) ? word_d[WIDTH-1] : word_d[0];
        else if (state_d == PARITY)
            s_out_d = par_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            word_q        <= '0;
            bit_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            par_q         <= 1'b0;
            s_out_q       <= 1'b0;
            s_valid_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state         <= state_d;
            word_q        <= word_d;
            bit_cnt_q     <= bit_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            par_q         <= par_d;
            s_out_q       <= s_out_d;
            s_valid_q     <= s_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.s_out       = s_out_q;
    assign bus.s_valid     = s_valid_q;
    assign bus.frame_start = frame_start_q;

endmodule
